// File: rtl/axo_dbg_pkg.sv
// Shared types and byte codes for the debug-command bus master.
package axo_dbg_pkg;

  typedef enum logic [2:0] {
    StCmd,
    StAddr,
    StWdata,
    StBus,
    StResp
  } dbg_state_e;

  localparam logic [7:0] AXO_DBG_RD = 8'h00;
  localparam logic [7:0] AXO_DBG_WR = 8'h01;

  localparam logic [7:0] AXO_DBG_OK       = 8'h00;
  localparam logic [7:0] AXO_DBG_EBADCMD  = 8'hE1;
  localparam logic [7:0] AXO_DBG_ETIMEOUT = 8'hEE;

  function automatic logic is_known_cmd(input logic [7:0] cmd);
    return (cmd == AXO_DBG_RD) || (cmd == AXO_DBG_WR);
  endfunction

endpackage

// File: rtl/axo_peri_bus.sv
// Simple peripheral bus: single-word read/write with a ready handshake.
interface axo_peri_bus #(
  parameter int unsigned alen = 12
);
  logic            re;
  logic            we;
  logic [alen-1:0] addr;
  logic [31:0]     wdata;
  logic            ready;
  logic [31:0]     rdata;

  modport CPU  (output re, we, addr, wdata, input ready, rdata);
  modport PERI (input re, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/axo_dbg_resp_ser.sv
// Response serializer: status byte, then optionally a 32-bit word as four LE bytes.
module axo_dbg_resp_ser (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  status,
  input  logic        has_data,
  input  logic [31:0] data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        done
);

  logic        valid_q;
  logic [7:0]  byte_q;
  logic [31:0] word_q;
  logic [2:0]  rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      byte_q  <= '0;
      word_q  <= '0;
      rem_q   <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      byte_q  <= status;
      word_q  <= data;
      rem_q   <= has_data ? 3'd4 : 3'd0;
    end else if (valid_q && out_ready) begin
      if (rem_q == 3'd0) begin
        valid_q <= 1'b0;
      end else begin
        byte_q <= word_q[7:0];
        word_q <= {8'h00, word_q[31:8]};
        rem_q  <= rem_q - 3'd1;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = byte_q;
  assign done      = valid_q && out_ready && (rem_q == 3'd0);

endmodule

// File: rtl/axo_peri_dbg_master.sv
// Byte-stream debug command parser driving one peripheral bus transaction per command.
module axo_peri_dbg_master
  import axo_dbg_pkg::*;
#(
  parameter int unsigned alen    = 12,
  parameter int unsigned timeout = 255
) (
  input  logic       clk,
  input  logic       rst,
  axo_peri_bus.CPU   bus,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy
);

  localparam int unsigned TW = $clog2(timeout + 1);

  dbg_state_e      state_q, state_d;
  logic [1:0]      cnt_q;
  logic            is_wr_q;
  logic [7:0]      addr_lo_q;
  logic [alen-1:0] addr_q;
  logic [31:0]     wdata_q;
  logic            re_q, we_q;
  logic [TW-1:0]   tmo_q;

  logic       in_fire, bus_act, bus_done, tmo_hit, start_bus;
  logic       ser_load, ser_has_data, ser_done;
  logic [7:0] ser_status;

  assign in_ready = (state_q == StCmd) || (state_q == StAddr) || (state_q == StWdata);
  assign in_fire  = in_valid && in_ready;
  assign bus_act  = re_q || we_q;
  assign bus_done = bus_act && bus.ready;
  assign tmo_hit  = bus_act && !bus.ready && (tmo_q == TW'(timeout - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StCmd;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    start_bus    = 1'b0;
    ser_load     = 1'b0;
    ser_status   = AXO_DBG_OK;
    ser_has_data = 1'b0;
    unique case (state_q)
      StCmd: begin
        if (in_fire) begin
          if (is_known_cmd(in_data)) begin
            state_d = StAddr;
          end else begin
            ser_load   = 1'b1;
            ser_status = AXO_DBG_EBADCMD;
            state_d    = StResp;
          end
        end
      end
      StAddr: begin
        if (in_fire && cnt_q[0]) begin
          if (is_wr_q) begin
            state_d = StWdata;
          end else begin
            start_bus = 1'b1;
            state_d   = StBus;
          end
        end
      end
      StWdata: begin
        if (in_fire && (cnt_q == 2'd3)) begin
          start_bus = 1'b1;
          state_d   = StBus;
        end
      end
      StBus: begin
        if (bus_done) begin
          ser_load     = 1'b1;
          ser_has_data = !is_wr_q;
          state_d      = StResp;
        end else if (tmo_hit) begin
          ser_load   = 1'b1;
          ser_status = AXO_DBG_ETIMEOUT;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (ser_done) state_d = StCmd;
      end
      default: state_d = StCmd;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      addr_lo_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      tmo_q     <= '0;
    end else begin
      if (in_fire) begin
        case (state_q)
          StCmd: begin
            is_wr_q <= (in_data == AXO_DBG_WR);
            cnt_q   <= '0;
          end
          StAddr: begin
            if (!cnt_q[0]) addr_lo_q <= in_data;
            else           addr_q    <= alen'({in_data, addr_lo_q});
            cnt_q <= cnt_q[0] ? 2'd0 : 2'd1;
          end
          StWdata: begin
            // Little-endian: each byte enters at the top and shifts down.
            wdata_q <= {in_data, wdata_q[31:8]};
            cnt_q   <= cnt_q + 2'd1;
          end
          default: ;
        endcase
      end

      // Strobe drops right after the completing edge, so a write is never seen twice.
      if (start_bus) begin
        re_q  <= ~is_wr_q;
        we_q  <= is_wr_q;
        tmo_q <= '0;
      end else if (bus_done || tmo_hit) begin
        re_q <= 1'b0;
        we_q <= 1'b0;
      end else if (bus_act) begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

  assign bus.re    = re_q;
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign busy      = (state_q != StCmd);

  axo_dbg_resp_ser u_resp_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .status    (ser_status),
    .has_data  (ser_has_data),
    .data      (bus.rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_axo_peri_dbg_master.sv
// Directed bench for the debug bus master with a frame-level expectation model.
module tb_axo_peri_dbg_master;

  localparam int unsigned ALEN = 12;
  localparam int unsigned TMO  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;
  logic       busy;

  axo_peri_bus #(.alen(ALEN)) bus ();

  axo_peri_dbg_master #(.alen(ALEN), .timeout(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: word memory, optional wait states, or never ready.
  logic [31:0] mem [0:(1<<ALEN)-1];
  int wait_cycles = 0;
  bit never_ready = 1'b0;
  int wait_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if ((bus.re || bus.we) && !bus.ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end
  assign bus.ready = (bus.re || bus.we) && !never_ready && (wait_cnt >= wait_cycles);
  assign bus.rdata = mem[bus.addr];
  always @(posedge clk) if (bus.we && bus.ready) mem[bus.addr] = bus.wdata;

  bit toggle = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = toggle ? ~out_ready : 1'b1;
  end

  typedef struct packed {
    logic            wr;
    logic [ALEN-1:0] addr;
    logic [31:0]     wd;
  } txn_t;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_resp [$];
  txn_t       exp_txn  [$];
  logic [7:0] rx_log   [$];
  logic [7:0] fb [7];

  int act_len = 0, last_len = 0, we_cycles = 0, rise_cyc = 0, last_edge = 0;
  logic [ALEN-1:0] act_addr;
  logic [7:0] held;
  bit ov_hold = 1'b0, prev_ov = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    txn_t t;
    if (rst) begin
      act_len = 0;
      ov_hold = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (bus.re || bus.we) begin
        chk("re_we_excl", 32'(bus.re & bus.we), 0);
        if (bus.we) we_cycles++;
        if (act_len > 0) chk("addr_stable", 32'(bus.addr), 32'(act_addr));
        act_addr = bus.addr;
        act_len++;
        if (bus.ready) begin
          if (exp_txn.size() == 0) begin
            total++;
            bad++;
            $display("FAIL bus_txn: got unexpected completion addr=%h want none", bus.addr);
          end else begin
            t = exp_txn.pop_front();
            chk("txn_kind", 32'(bus.we), 32'(t.wr));
            chk("txn_addr", 32'(bus.addr), 32'(t.addr));
            if (t.wr) chk("txn_wdata", bus.wdata, t.wd);
          end
          last_len = act_len;
          act_len  = 0;
        end
      end else if (act_len > 0) begin
        last_len = act_len;
        act_len  = 0;
      end

      if (out_valid) begin
        chk("in_ready_in_resp", 32'(in_ready), 0);
        if (ov_hold) chk("resp_hold", 32'(out_data), 32'(held));
        if (out_ready) begin
          if (exp_resp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL resp_byte: got unexpected %h want none", out_data);
          end else begin
            chk("resp_byte", 32'(out_data), 32'(exp_resp.pop_front()));
          end
          rx_log.push_back(out_data);
          ov_hold = 1'b0;
        end else begin
          ov_hold = 1'b1;
          held    = out_data;
        end
        if (!prev_ov) rise_cyc = cyc;
      end else if (ov_hold) begin
        chk("resp_dropped", 32'(out_valid), 1);
        ov_hold = 1'b0;
      end
      prev_ov = out_valid;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        chk("in_ready_wait", 32'(in_ready), 1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    last_edge = cyc;
  endtask

  // Model: derive bus transaction and response bytes from the frame contents.
  task automatic frame(input int n);
    logic [15:0]     a16;
    logic [ALEN-1:0] a;
    logic [31:0]     w;
    txn_t            t;
    a16 = {fb[2], fb[1]};
    a   = a16[ALEN-1:0];
    w   = {fb[6], fb[5], fb[4], fb[3]};
    if (fb[0] == 8'h00 || fb[0] == 8'h01) begin
      if (never_ready) begin
        exp_resp.push_back(8'hEE);
      end else begin
        t.wr = fb[0][0];
        t.addr = a;
        t.wd = w;
        exp_txn.push_back(t);
        exp_resp.push_back(8'h00);
        if (fb[0] == 8'h00) begin
          w = mem[a];
          for (int i = 0; i < 4; i++) exp_resp.push_back(w[8*i +: 8]);
        end
      end
    end else begin
      exp_resp.push_back(8'hE1);
    end
    for (int i = 0; i < n; i++) send_byte(fb[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy && !out_valid && exp_resp.size() == 0) break;
      n++;
      if (n > 300) begin
        chk("idle_wait", 32'(busy), 0);
        exp_resp.delete();
        exp_txn.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctrl"}, {28'h0, bus.re, bus.we, out_valid, busy}, 0);
    chk({nm, "_addr"}, 32'(bus.addr), 0);
    chk({nm, "_wdata"}, bus.wdata, 0);
    chk({nm, "_out_data"}, 32'(out_data), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int we_before;
    logic [7:0] lit [5];
    for (int i = 0; i < (1 << ALEN); i++) mem[i] = 32'h0;
    mem[0]      = 32'hDEADBEEF;
    mem[12'h123] = 32'hCAFEF00D;
    mem[12'h234] = 32'h0BADC0DE;
    #3;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: write to GPIO word 1
    fb = '{8'h01, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    frame(7);
    wait_idle();
    chk("wr_gpio_level", mem[1], 32'h12345678);
    chk("wr_we_cycles", last_len, 1);

    // 2: read word 0, latency and literal byte order
    rx_log.delete();
    fb = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(3);
    wait_idle();
    // out_valid rises on the edge after the last byte edge, i.e. visible in cycle N+2
    chk("rd_latency_edges", rise_cyc - last_edge, 1);
    chk("rd_re_cycles", last_len, 1);
    lit = '{8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    chk("rd_resp_len", rx_log.size(), 5);
    for (int i = 0; i < 5 && i < rx_log.size(); i++) chk("rd_resp_lit", 32'(rx_log[i]), 32'(lit[i]));

    // 3a: five wait states
    wait_cycles = 5;
    fb = '{8'h00, 8'h23, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(3);
    wait_idle();
    chk("wait_re_cycles", last_len, 6);
    wait_cycles = 0;

    // 3b: timeout, upper address bits ignored
    never_ready = 1'b1;
    rx_log.delete();
    fb = '{8'h00, 8'h34, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(3);
    wait_idle();
    never_ready = 1'b0;
    chk("tmo_re_cycles", last_len, 8);
    chk("tmo_resp_len", rx_log.size(), 1);
    if (rx_log.size() > 0) chk("tmo_status", 32'(rx_log[0]), 32'hEE);

    // 4: bad command, then a normal read
    fb = '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(1);
    chk("badcmd_in_ready", 32'(in_ready), 0);
    wait_idle();
    fb = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(3);
    wait_idle();

    // 5: output backpressure plus ignored command pulses during the response
    toggle = 1'b1;
    rx_log.delete();
    fb = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(3);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_valid_seen", 32'(out_valid), 1);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h01;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    wait_idle();
    toggle = 1'b0;
    chk("bp_resp_len", rx_log.size(), 5);
    if (rx_log.size() > 4) chk("bp_last_byte", 32'(rx_log[4]), 32'hDE);

    // 6a: reset mid-WDATA
    we_before = we_cycles;
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero("rst_wdata");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_wdata_no_we", we_cycles, we_before);
    chk("rst_wdata_mem", mem[3], 0);

    // 6b: reset mid-BUS with a stalled write
    never_ready = 1'b1;
    fb = '{8'h01, 8'h04, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 7; i++) send_byte(fb[i]);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_bus_we_high", 32'(bus.we), 1);
    rst = 1'b1;
    #1;
    chk_zero("rst_bus");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    never_ready = 1'b0;
    chk("rst_bus_mem", mem[4], 0);

    // Fresh frame after reset; 0xF0 high byte is outside the 12-bit address
    fb = '{8'h01, 8'h02, 8'hF0, 8'h5A, 8'h5A, 8'hA5, 8'hA5};
    frame(7);
    wait_idle();
    chk("post_rst_write", mem[2], 32'hA5A55A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
